uart_json_rx: RTL and testbench
===============================

UART_JSON_RX -- requirements
Module: uart_json_rx

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clocks per UART bit (115200 baud at 50 MHz).
REQ-003 The block SHALL have the following ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- uart_in  in  1  UART RX line (8N1, idle high, LSB first).
- rx_byte  out  8  last correctly framed byte.
- rx_byte_valid  out  1  one-cycle pulse per correctly framed byte.
- cmd_valid  out  1  one-cycle pulse when a complete command is decoded.
- cmd_type  out  8  decoded T value, unsigned integer.
- left_speed  out  11  decoded L value, signed two's complement, in hundredths.
- right_speed  out  11  decoded R value, signed two's complement, in hundredths.
- parse_error  out  1  one-cycle pulse on a framing or syntax error.

Function
REQ-004 uart_in SHALL pass through a 2-flop synchronizer before any use.
REQ-005 The UART RX FSM SHALL use the states IDLE, START, DATA and STOP:
- IDLE to START: on a synchronized falling edge.
- START: after CLKS_PER_BIT/2 clocks, if the line is low go to DATA, otherwise it is a false start and the FSM returns to IDLE with no pulse.
- DATA: sample 8 bits, one every CLKS_PER_BIT clocks.
- STOP: sample after CLKS_PER_BIT clocks.
REQ-006 On a stop bit of 1, the block SHALL update rx_byte and pulse rx_byte_valid in the cycle after the stop sample.
- On a stop bit of 0, the byte is discarded, parse_error pulses and the parser returns to IDLE.
REQ-007 The parser SHALL consume each rx_byte_valid byte using the states P_IDLE, P_KQ1, P_KEY, P_KQ2, P_COLON, P_VAL, P_SEP and P_NL.
REQ-008 Grammar: '{' '"' key '"' ':' value, then ',' for the next pair or '}' to close, then 0x0A.
- key is one of 'T', 'L' or 'R'.
- 0x20 (space) is ignored in every state except P_VAL.
REQ-009 Value syntax:
- optional minus sign, accepted as 0x2D or 0x96;
- one integer digit;
- optionally '.' followed by 1 to 2 fraction digits.
- One fraction digit is scaled by 10.
REQ-010 Value arithmetic: value = int*100 + frac, negated when the sign is present, giving a range of -999..999 in 11-bit signed.
- For T, the value SHALL be the integer digit only, and a sign or fraction on T is an error.
REQ-011 The parser SHALL use a 3-bit seen mask; a duplicate key, an unknown key, a missing digit, an extra digit or any unexpected byte is an error.
REQ-012 On an error, the block SHALL pulse parse_error once, discard the partial values and return the parser to P_IDLE.
REQ-013 A '{' received in any parser state SHALL restart the parse: the partial values are discarded and no error is raised.
REQ-014 On 0x0A in P_NL, if the seen mask is 3'b111, the block SHALL pulse cmd_valid in the cycle after the '\n' rx_byte_valid pulse.
- In that same cycle, cmd_type, left_speed and right_speed update atomically.
- If the mask is not all set, parse_error pulses instead.
REQ-015 Decoded outputs SHALL hold their values until the next cmd_valid; errors never alter them.
REQ-016 cmd_valid and parse_error SHALL never assert in the same cycle.
REQ-017 Bytes received while the parser is in P_IDLE, other than '{' and space, SHALL be dropped silently with no error.

Reset
REQ-018 While rst is high, the block SHALL hold:
- rx_byte=0, rx_byte_valid=0, cmd_valid=0, parse_error=0;
- cmd_type=0, left_speed=0, right_speed=0;
- both FSMs in IDLE, all counters 0, seen mask 0;
- synchronizer flops = 1.
REQ-019 If reset asserts mid-byte or mid-command, the partial data SHALL be lost, and after release the block waits for a fresh falling edge.

Verification
REQ-020 Stimulus `{"T":1,"L":0x96 0.25,"R":0.25}\n` at 434 clk/bit -> one cmd_valid, cmd_type=1, left_speed=-25 (11'h7E7), right_speed=25.
REQ-021 Stimulus `{"T":1,"L":0.5,"R":0.5}\n`, then `{"T":1,"L":0,"R":0}\n` -> cmd_valid twice, with outputs 50/50 and then 0/0.
REQ-022 Stimulus of the byte 0x41 with stop bit 0 in the middle of a command -> parse_error pulse and no cmd_valid.
- A following valid command -> decoded correctly.
REQ-023 Stimulus `{"T":1,"L":0.25}\n` (R missing) -> parse_error on '\n' and outputs unchanged; `{"T":1,"L":0.25,"L":0.25,...}` -> parse_error on the second 'L'.
REQ-024 Stimulus of a 100-clock low glitch on idle uart_in -> no rx_byte_valid and no error.
- Then `{"T":1,{"T":2,"L":1.00,"R":-1}\n` -> cmd_valid with T=2, L=100, R=-100.
REQ-025 Stimulus of rst asserted during bit 4 of '}' -> all outputs 0.
- After release, a full valid command decodes correctly.

Source files
------------

// File: rtl/uart_json_rx.sv
`default_nettype none
//==============================================================================
// Module   : uart_json_rx
// Brief    : 8N1 UART receiver feeding a JSON {"T":..,"L":..,"R":..} decoder.
// Revision : 1.0 - initial release
//==============================================================================
module uart_json_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_in,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        cmd_valid,
    output logic [7:0]  cmd_type,
    output logic [10:0] left_speed,
    output logic [10:0] right_speed,
    output logic        parse_error
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    localparam logic [2:0] c_P_IDLE  = 3'd0;
    localparam logic [2:0] c_P_KQ1   = 3'd1;
    localparam logic [2:0] c_P_KEY   = 3'd2;
    localparam logic [2:0] c_P_KQ2   = 3'd3;
    localparam logic [2:0] c_P_COLON = 3'd4;
    localparam logic [2:0] c_P_VAL   = 3'd5;
    localparam logic [2:0] c_P_SEP   = 3'd6;
    localparam logic [2:0] c_P_NL    = 3'd7;

    localparam logic [2:0] c_V_START = 3'd0;
    localparam logic [2:0] c_V_SIGN  = 3'd1;
    localparam logic [2:0] c_V_INT   = 3'd2;
    localparam logic [2:0] c_V_DOT   = 3'd3;
    localparam logic [2:0] c_V_FR1   = 3'd4;
    localparam logic [2:0] c_V_FR2   = 3'd5;

    localparam logic [1:0] c_KEY_T = 2'd0;
    localparam logic [1:0] c_KEY_L = 2'd1;
    localparam logic [1:0] c_KEY_R = 2'd2;

    localparam logic [7:0] c_CH_LBRACE = 8'h7B;
    localparam logic [7:0] c_CH_RBRACE = 8'h7D;
    localparam logic [7:0] c_CH_QUOTE  = 8'h22;
    localparam logic [7:0] c_CH_COLON  = 8'h3A;
    localparam logic [7:0] c_CH_COMMA  = 8'h2C;
    localparam logic [7:0] c_CH_DOT    = 8'h2E;
    localparam logic [7:0] c_CH_SPACE  = 8'h20;
    localparam logic [7:0] c_CH_MINUS  = 8'h2D;
    localparam logic [7:0] c_CH_MINUS2 = 8'h96;
    localparam logic [7:0] c_CH_NL     = 8'h0A;
    localparam logic [7:0] c_CH_T      = 8'h54;
    localparam logic [7:0] c_CH_L      = 8'h4C;
    localparam logic [7:0] c_CH_R      = 8'h52;

    // ---------------- UART receiver ----------------
    logic               r_sync1, r_sync2, r_sync_d;
    logic [1:0]         r_rx_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_byte;
    logic               r_rx_valid;
    logic               r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_d    <= 1'b1;
            r_rx_state  <= c_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_rx_byte   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= uart_in;
            r_sync2     <= r_sync1;
            r_sync_d    <= r_sync2;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_rx_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (r_sync_d && !r_sync2) r_rx_state <= c_START;
                end
                c_START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt      <= '0;
                        r_bit_idx  <= 3'd0;
                        r_rx_state <= r_sync2 ? c_IDLE : c_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_rx_state <= c_STOP;
                        else                   r_bit_idx  <= r_bit_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == c_FULL_M1) begin
                        r_cnt      <= '0;
                        r_rx_state <= c_IDLE;
                        if (r_sync2) begin
                            r_rx_byte  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- JSON parser ----------------
    logic [2:0]  r_p_state, w_p_state_n;
    logic [2:0]  r_vphase, w_vphase_n;
    logic [1:0]  r_key, w_key_n;
    logic [2:0]  r_seen, w_seen_n;
    logic        r_neg, w_neg_n;
    logic [3:0]  r_int, w_int_n;
    logic [6:0]  r_frac, w_frac_n;
    logic [7:0]  r_t_acc;
    logic [10:0] r_l_acc, r_r_acc;
    logic [7:0]  r_cmd_type;
    logic [10:0] r_left, r_right;
    logic        r_cmd_valid, r_parse_error;
    logic        w_commit, w_cmd, w_err;
    logic        w_is_digit, w_is_sign, w_val_done;
    logic [3:0]  w_digit;
    logic [10:0] w_mag, w_val;
    logic [2:0]  w_key_bit;

    assign w_is_digit = (r_rx_byte >= 8'h30) && (r_rx_byte <= 8'h39);
    assign w_is_sign  = (r_rx_byte == c_CH_MINUS) || (r_rx_byte == c_CH_MINUS2);
    assign w_digit    = r_rx_byte[3:0];
    assign w_mag      = 11'(r_int) * 11'd100 + 11'(r_frac);
    assign w_val      = r_neg ? (~w_mag + 11'd1) : w_mag;
    assign w_key_bit  = 3'b001 << r_key;
    assign w_val_done = (r_vphase == c_V_INT) || (r_vphase == c_V_FR1) || (r_vphase == c_V_FR2);

    always_comb begin
        w_p_state_n = r_p_state;
        w_vphase_n  = r_vphase;
        w_key_n     = r_key;
        w_seen_n    = r_seen;
        w_neg_n     = r_neg;
        w_int_n     = r_int;
        w_frac_n    = r_frac;
        w_commit    = 1'b0;
        w_cmd       = 1'b0;
        w_err       = 1'b0;
        if (r_frame_err) begin
            w_err = 1'b1;
        end else if (r_rx_valid) begin
            if (r_rx_byte == c_CH_LBRACE) begin
                w_p_state_n = c_P_KQ1;
                w_seen_n    = 3'b000;
            end else if (!(r_rx_byte == c_CH_SPACE && r_p_state != c_P_VAL)) begin
                case (r_p_state)
                    c_P_IDLE: begin
                    end
                    c_P_KQ1: begin
                        if (r_rx_byte == c_CH_QUOTE) w_p_state_n = c_P_KEY;
                        else                         w_err = 1'b1;
                    end
                    c_P_KEY: begin
                        w_p_state_n = c_P_KQ2;
                        if (r_rx_byte == c_CH_T && !r_seen[0])      w_key_n = c_KEY_T;
                        else if (r_rx_byte == c_CH_L && !r_seen[1]) w_key_n = c_KEY_L;
                        else if (r_rx_byte == c_CH_R && !r_seen[2]) w_key_n = c_KEY_R;
                        else                                        w_err = 1'b1;
                    end
                    c_P_KQ2: begin
                        if (r_rx_byte == c_CH_QUOTE) w_p_state_n = c_P_COLON;
                        else                         w_err = 1'b1;
                    end
                    c_P_COLON: begin
                        if (r_rx_byte == c_CH_COLON) begin
                            w_p_state_n = c_P_VAL;
                            w_vphase_n  = c_V_START;
                            w_neg_n     = 1'b0;
                            w_int_n     = 4'd0;
                            w_frac_n    = 7'd0;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    c_P_VAL: begin
                        if ((r_vphase == c_V_START || r_vphase == c_V_SIGN) && w_is_digit) begin
                            w_int_n    = w_digit;
                            w_vphase_n = c_V_INT;
                        end else if (r_vphase == c_V_START && w_is_sign && r_key != c_KEY_T) begin
                            w_neg_n    = 1'b1;
                            w_vphase_n = c_V_SIGN;
                        end else if (r_vphase == c_V_INT && r_rx_byte == c_CH_DOT && r_key != c_KEY_T) begin
                            w_vphase_n = c_V_DOT;
                        end else if (r_vphase == c_V_DOT && w_is_digit) begin
                            w_frac_n   = 7'(w_digit) * 7'd10;
                            w_vphase_n = c_V_FR1;
                        end else if (r_vphase == c_V_FR1 && w_is_digit) begin
                            w_frac_n   = r_frac + 7'(w_digit);
                            w_vphase_n = c_V_FR2;
                        end else if (w_val_done && r_rx_byte == c_CH_COMMA) begin
                            w_commit    = 1'b1;
                            w_p_state_n = c_P_KQ1;
                        end else if (w_val_done && r_rx_byte == c_CH_RBRACE) begin
                            w_commit    = 1'b1;
                            w_p_state_n = c_P_NL;
                        end else if (w_val_done && r_rx_byte == c_CH_SPACE) begin
                            // a space terminates the value; the separator follows in P_SEP
                            w_commit    = 1'b1;
                            w_p_state_n = c_P_SEP;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    c_P_SEP: begin
                        if (r_rx_byte == c_CH_COMMA)       w_p_state_n = c_P_KQ1;
                        else if (r_rx_byte == c_CH_RBRACE) w_p_state_n = c_P_NL;
                        else                               w_err = 1'b1;
                    end
                    c_P_NL: begin
                        if (r_rx_byte == c_CH_NL && (&r_seen)) begin
                            w_cmd       = 1'b1;
                            w_p_state_n = c_P_IDLE;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                endcase
            end
        end
        if (w_commit) w_seen_n = r_seen | w_key_bit;
        if (w_err) begin
            w_p_state_n = c_P_IDLE;
            w_seen_n    = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_state     <= c_P_IDLE;
            r_vphase      <= c_V_START;
            r_key         <= c_KEY_T;
            r_seen        <= 3'b000;
            r_neg         <= 1'b0;
            r_int         <= 4'd0;
            r_frac        <= 7'd0;
            r_t_acc       <= 8'd0;
            r_l_acc       <= 11'd0;
            r_r_acc       <= 11'd0;
            r_cmd_type    <= 8'd0;
            r_left        <= 11'd0;
            r_right       <= 11'd0;
            r_cmd_valid   <= 1'b0;
            r_parse_error <= 1'b0;
        end else begin
            r_p_state     <= w_p_state_n;
            r_vphase      <= w_vphase_n;
            r_key         <= w_key_n;
            r_seen        <= w_seen_n;
            r_neg         <= w_neg_n;
            r_int         <= w_int_n;
            r_frac        <= w_frac_n;
            r_cmd_valid   <= w_cmd;
            r_parse_error <= w_err;
            if (w_commit) begin
                case (r_key)
                    c_KEY_T: r_t_acc <= {4'd0, r_int};
                    c_KEY_L: r_l_acc <= w_val;
                    default: r_r_acc <= w_val;
                endcase
            end
            if (w_cmd) begin
                r_cmd_type <= r_t_acc;
                r_left     <= r_l_acc;
                r_right    <= r_r_acc;
            end
        end
    end

    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_rx_valid;
    assign cmd_valid     = r_cmd_valid;
    assign cmd_type      = r_cmd_type;
    assign left_speed    = r_left;
    assign right_speed   = r_right;
    assign parse_error   = r_parse_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_json_rx.sv
`default_nettype none
//==============================================================================
// Module   : tb_uart_json_rx
// Brief    : Self-checking bench for uart_json_rx with generated JSON commands.
// Revision : 1.0 - initial release
//==============================================================================
module tb_uart_json_rx;

    localparam int CPB = 8;

    logic        clk;
    logic        rst;
    logic        uart_in;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        cmd_valid;
    logic [7:0]  cmd_type;
    logic [10:0] left_speed;
    logic [10:0] right_speed;
    logic        parse_error;

    uart_json_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_in       (uart_in),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .cmd_valid     (cmd_valid),
        .cmd_type      (cmd_type),
        .left_speed    (left_speed),
        .right_speed   (right_speed),
        .parse_error   (parse_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int n_rxv, n_cmd, n_err, n_both;
    int exp_t, exp_l, exp_r;
    logic [7:0] q[$];

    always @(negedge clk) begin
        if (rx_byte_valid) n_rxv++;
        if (cmd_valid) n_cmd++;
        if (parse_error) n_err++;
        if (cmd_valid && parse_error) n_both++;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 90000 cycles, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void put_str(input string s);
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endfunction

    function automatic void put_sp();
        if ($urandom_range(1, 0) == 1) q.push_back(8'h20);
    endfunction

    // Decimal rendering of a hundredths value with a random but legal layout.
    function automatic void put_val(input int v);
        int m, ip, fp, s;
        m  = (v < 0) ? -v : v;
        ip = m / 100;
        fp = m % 100;
        if (v < 0 || (v == 0 && $urandom_range(1, 0) == 1))
            q.push_back(($urandom_range(1, 0) == 1) ? 8'h2D : 8'h96);
        q.push_back(8'(8'h30 + ip));
        if (fp == 0) begin
            s = int'($urandom_range(2, 0));
            if (s >= 1) begin
                q.push_back(8'h2E);
                q.push_back(8'h30);
                if (s == 2) q.push_back(8'h30);
            end
        end else if (fp % 10 == 0) begin
            q.push_back(8'h2E);
            q.push_back(8'(8'h30 + fp / 10));
            if ($urandom_range(1, 0) == 1) q.push_back(8'h30);
        end else begin
            q.push_back(8'h2E);
            q.push_back(8'(8'h30 + fp / 10));
            q.push_back(8'(8'h30 + fp % 10));
        end
    endfunction

    function automatic void put_cmd(input int t, input int l, input int r);
        int ord[3];
        int j, tmp;
        ord = '{0, 1, 2};
        for (int i = 2; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
        end
        q.push_back(8'h7B);
        for (int i = 0; i < 3; i++) begin
            put_sp();
            q.push_back(8'h22);
            q.push_back((ord[i] == 0) ? 8'h54 : (ord[i] == 1) ? 8'h4C : 8'h52);
            q.push_back(8'h22);
            put_sp();
            q.push_back(8'h3A);
            if (ord[i] == 0) q.push_back(8'(8'h30 + t));
            else             put_val((ord[i] == 1) ? l : r);
            q.push_back((i == 2) ? 8'h7D : 8'h2C);
        end
        put_sp();
        q.push_back(8'h0A);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_in = stop;
        repeat (CPB) @(posedge clk);
        uart_in = 1'b1;
        if (!stop) repeat (CPB) @(posedge clk);
    endtask

    task automatic send_q();
        while (q.size() > 0) send_byte(q.pop_front(), 1'b1);
        repeat (CPB) @(posedge clk);
        @(negedge clk);
    endtask

    // Sends one well-formed command and checks it decodes to (t, l, r).
    task automatic run_good_cmd(input string name, input int t, input int l, input int r);
        int c0, e0, b0, nb;
        c0 = n_cmd; e0 = n_err; b0 = n_rxv;
        put_cmd(t, l, r);
        nb = q.size();
        send_q();
        exp_t = t; exp_l = l; exp_r = r;
        total++;
        if (n_cmd - c0 !== 1 || n_err - e0 !== 0) begin
            bad++;
            $display("FAIL %s_pulses: cmd=%0d err=%0d, required cmd=1 err=0", name, n_cmd - c0, n_err - e0);
        end
        total++;
        if ({cmd_type, left_speed, right_speed} !== {8'(t), 11'(l), 11'(r)}) begin
            bad++;
            $display("FAIL %s_values: T=%0d L=%0d R=%0d, required T=%0d L=%0d R=%0d",
                     name, cmd_type, $signed(left_speed), $signed(right_speed), t, l, r);
        end
        total++;
        if (n_rxv - b0 !== nb || rx_byte !== 8'h0A) begin
            bad++;
            $display("FAIL %s_bytes: count=%0d last=%h, required count=%0d last=0a", name, n_rxv - b0, rx_byte, nb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rx_byte, rx_byte_valid, cmd_valid, parse_error} !== 11'd0) begin
            bad++;
            $display("FAIL reset_rx: rx_byte=%h v=%b c=%b e=%b, required all 0", rx_byte, rx_byte_valid, cmd_valid, parse_error);
        end
        total++;
        if ({cmd_type, left_speed, right_speed} !== 30'd0) begin
            bad++;
            $display("FAIL reset_cmd: T=%h L=%h R=%h, required 0", cmd_type, left_speed, right_speed);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        exp_t = 0; exp_l = 0; exp_r = 0;
    endtask

    task automatic test_negative_fraction();
        int c0;
        c0 = n_cmd;
        put_str("{\"T\":1,\"L\":");
        q.push_back(8'h96);
        put_str("0.25,\"R\":0.25}\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 1 || cmd_type !== 8'd1 || left_speed !== 11'h7E7 || right_speed !== 11'd25) begin
            bad++;
            $display("FAIL neg_fraction: n=%0d T=%0d L=%h R=%0d, required n=1 T=1 L=7e7 R=25",
                     n_cmd - c0, cmd_type, left_speed, right_speed);
        end
        exp_t = 1; exp_l = -25; exp_r = 25;
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = n_cmd;
        put_str("{\"T\":1,\"L\":0.5,\"R\":0.5}\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 1 || left_speed !== 11'd50 || right_speed !== 11'd50) begin
            bad++;
            $display("FAIL b2b_first: n=%0d L=%0d R=%0d, required n=1 L=50 R=50", n_cmd - c0, left_speed, right_speed);
        end
        put_str("{\"T\":1,\"L\":0,\"R\":0}\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 2 || left_speed !== 11'd0 || right_speed !== 11'd0 || cmd_type !== 8'd1) begin
            bad++;
            $display("FAIL b2b_second: n=%0d T=%0d L=%0d R=%0d, required n=2 T=1 L=0 R=0",
                     n_cmd - c0, cmd_type, left_speed, right_speed);
        end
        exp_t = 1; exp_l = 0; exp_r = 0;
    endtask

    task automatic test_frame_error();
        int c0, e0;
        c0 = n_cmd; e0 = n_err;
        put_str("{\"T\":1,\"L\":0.");
        send_q();
        send_byte(8'h41, 1'b0);
        @(negedge clk);
        total++;
        if (n_err - e0 !== 1 || rx_byte !== 8'h2E) begin
            bad++;
            $display("FAIL frame_err: errs=%0d rx_byte=%h, required errs=1 rx_byte=2e", n_err - e0, rx_byte);
        end
        put_str("5,\"R\":0.5}\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 0 || n_err - e0 !== 1 ||
            {cmd_type, left_speed, right_speed} !== {8'(exp_t), 11'(exp_l), 11'(exp_r)}) begin
            bad++;
            $display("FAIL frame_tail: cmd=%0d err=%0d T=%0d L=%0d R=%0d, required cmd=0 err=1 unchanged",
                     n_cmd - c0, n_err - e0, cmd_type, $signed(left_speed), $signed(right_speed));
        end
        run_good_cmd("frame_recover", 4, -130, 707);
    endtask

    task automatic test_missing_key();
        int c0, e0;
        c0 = n_cmd; e0 = n_err;
        put_str("{\"T\":1,\"L\":0.25}");
        send_q();
        total++;
        if (n_err - e0 !== 0) begin
            bad++;
            $display("FAIL missing_early: errs=%0d before newline, required 0", n_err - e0);
        end
        put_str("\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 0 || n_err - e0 !== 1 ||
            {cmd_type, left_speed, right_speed} !== {8'(exp_t), 11'(exp_l), 11'(exp_r)}) begin
            bad++;
            $display("FAIL missing_key: cmd=%0d err=%0d T=%0d L=%0d R=%0d, required cmd=0 err=1 unchanged",
                     n_cmd - c0, n_err - e0, cmd_type, $signed(left_speed), $signed(right_speed));
        end
    endtask

    task automatic test_duplicate_key();
        int c0, e0;
        c0 = n_cmd; e0 = n_err;
        put_str("{\"T\":1,\"L\":0.25,\"");
        send_q();
        total++;
        if (n_err - e0 !== 0) begin
            bad++;
            $display("FAIL dup_early: errs=%0d, required 0", n_err - e0);
        end
        put_str("L");
        send_q();
        total++;
        if (n_err - e0 !== 1) begin
            bad++;
            $display("FAIL dup_key: errs=%0d after second L, required 1", n_err - e0);
        end
        put_str("\":0.25,\"R\":0.5}\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 0 || n_err - e0 !== 1) begin
            bad++;
            $display("FAIL dup_tail: cmd=%0d err=%0d, required cmd=0 err=1", n_cmd - c0, n_err - e0);
        end
    endtask

    task automatic test_glitch_restart();
        int c0, e0, b0;
        c0 = n_cmd; e0 = n_err; b0 = n_rxv;
        uart_in = 1'b0;
        repeat (2) @(posedge clk);
        uart_in = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        total++;
        if (n_rxv - b0 !== 0 || n_err - e0 !== 0) begin
            bad++;
            $display("FAIL glitch: bytes=%0d errs=%0d, required 0 0", n_rxv - b0, n_err - e0);
        end
        put_str("{\"T\":1,{\"T\":2,\"L\":1.00,\"R\":-1}\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 1 || n_err - e0 !== 0 || cmd_type !== 8'd2 ||
            left_speed !== 11'd100 || right_speed !== 11'h79C) begin
            bad++;
            $display("FAIL restart: cmd=%0d err=%0d T=%0d L=%0d R=%0d, required 1 0 T=2 L=100 R=-100",
                     n_cmd - c0, n_err - e0, cmd_type, $signed(left_speed), $signed(right_speed));
        end
        exp_t = 2; exp_l = 100; exp_r = -100;
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b;
        b = 8'h7D;
        put_str("{\"T\":3,\"L\":0.5,\"R\":0.5");
        send_q();
        uart_in = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_in = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_in = b[4];
        repeat (CPB / 2) @(posedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rx_byte, rx_byte_valid, cmd_valid, parse_error, cmd_type, left_speed, right_speed} !== 41'd0) begin
            bad++;
            $display("FAIL reset_mid: rx=%h T=%0d L=%0d R=%0d, required all 0", rx_byte, cmd_type, left_speed, right_speed);
        end
        uart_in = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_t = 0; exp_l = 0; exp_r = 0;
        repeat (CPB) @(posedge clk);
        run_good_cmd("after_reset", 6, 999, -999);
    endtask

    task automatic test_random();
        int t, l, r, e0, c0;
        for (int k = 0; k < 5; k++) begin
            t = int'($urandom_range(9, 0));
            l = int'($urandom_range(1998, 0)) - 999;
            r = int'($urandom_range(1998, 0)) - 999;
            run_good_cmd("random", t, l, r);
        end
        c0 = n_cmd; e0 = n_err;
        put_str((($urandom_range(1, 0) == 1) ? "{\"T\":-1," : "{\"T\":1.5,"));
        put_str("\"L\":0,\"R\":0}\n");
        send_q();
        total++;
        if (n_cmd - c0 !== 0 || n_err - e0 !== 1 ||
            {cmd_type, left_speed, right_speed} !== {8'(exp_t), 11'(exp_l), 11'(exp_r)}) begin
            bad++;
            $display("FAIL t_syntax: cmd=%0d err=%0d, required cmd=0 err=1 unchanged", n_cmd - c0, n_err - e0);
        end
        total++;
        if (n_both !== 0) begin
            bad++;
            $display("FAIL exclusive: overlap cycles=%0d, required 0", n_both);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        n_rxv = 0; n_cmd = 0; n_err = 0; n_both = 0;
        rst = 1'b1;
        uart_in = 1'b1;
        test_reset();
        test_negative_fraction();
        test_back_to_back();
        test_frame_error();
        test_missing_key();
        test_duplicate_key();
        test_glitch_restart();
        test_reset_mid_byte();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
